// File: rtl/pulse_capture_555_if.sv
// Bus between the 555 period-capture block and its driver/readout logic.
// The master side drives sig_in, start and ena; the slave side returns status and results.
interface pulse_capture_555_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             ena;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;

  modport master (
    output ena, sig_in, start,
    input  busy, done, ovf, high_cnt, low_cnt
  );

  modport slave (
    input  ena, sig_in, start,
    output busy, done, ovf, high_cnt, low_cnt
  );
endinterface

// File: rtl/pulse_capture_555.sv
// Measures one period of the asynchronous 555 OUT signal as high/low cycle counts.
// Define PULSE_CAPTURE_CONTINUOUS_EN for gap-free back-to-back period capture.
module pulse_capture_555 #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  pulse_capture_555_if.slave bus
);
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitRise = 3'd1;
  localparam logic [2:0] StMeasHigh = 3'd2;
  localparam logic [2:0] StMeasLow  = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [CNT_W-1:0]       low_q, low_d;
  logic                   ovf_q, ovf_d;
  logic                   s, rise, fall, cnt_max;
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
  // Delayed done for the rise that ends MEAS_LOW, since the FSM skips StDone.
  logic                   pend_q, pend_d;
`endif

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign cnt_max = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    ovf_d   = ovf_q;
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
    pend_d  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeasHigh;
        end else if (cnt_max) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StMeasHigh: begin
        if (fall) begin
          high_d  = cnt_q;
          cnt_d   = CntOne;
          state_d = StMeasLow;
        end else if (cnt_max) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else if (s) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StMeasLow: begin
        if (rise) begin
          low_d   = cnt_q;
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
          cnt_d   = CntOne;
          pend_d  = 1'b1;
          state_d = StMeasHigh;
`else
          state_d = StDone;
`endif
        end else if (cnt_max) begin
          ovf_d   = 1'b1;
          state_d = StDone;
        end else if (!s) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
    // Abort overrides everything decided above; no result or flag changes.
    if (bus.start && (state_q == StWaitRise || state_q == StMeasHigh ||
                      state_q == StMeasLow)) begin
      state_d = StIdle;
      cnt_d   = cnt_q;
      high_d  = high_q;
      low_d   = low_q;
      ovf_d   = ovf_q;
      pend_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
      pend_q  <= 1'b0;
`endif
    end else if (bus.ena) begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d_q   <= s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      ovf_q   <= ovf_d;
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.busy     = (state_q != StIdle);
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
  assign bus.done     = bus.ena & ((state_q == StDone) | pend_q);
`else
  assign bus.done     = bus.ena & (state_q == StDone);
`endif
  assign bus.ovf      = ovf_q;
  assign bus.high_cnt = high_q;
  assign bus.low_cnt  = low_q;
endmodule

// File: tb/tb_pulse_capture_555.sv
// Scoreboard bench for pulse_capture_555: expected results are queued as stimulus is driven
// and compared against the outputs on every done pulse.
module tb_pulse_capture_555;
  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] hi;
    logic [CW-1:0] lo;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   done_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_capture_555_if #(.CNT_W(CW)) bus ();

  pulse_capture_555 #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e, got;
    if (bus.done === 1'b1) begin
      done_seen++;
      done_cyc_q.push_back(cyc);
      got = {bus.high_cnt, bus.low_cnt, bus.ovf};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got hi=%0d lo=%0d ovf=%0d, no result expected",
                 got.hi, got.lo, got.ovf);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result got hi=%0d lo=%0d ovf=%0d want hi=%0d lo=%0d ovf=%0d",
                   got.hi, got.lo, got.ovf, e.hi, e.lo, e.ovf);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.sig_in = v;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit got);
    got = 1'b0;
    n   = 0;
    while (!got && n < limit) begin
      tick();
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  // Continuous capture keeps running after a done; return it to idle between scenarios.
  task automatic stop_cont();
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
    pulse_start();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sig_in = i[0];
      tick();
    end
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b ovf=%b hi=%0d lo=%0d want all 0",
               bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sig_in = i[1];
      tick();
    end
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt} !== '0) begin
      errors++;
      $display("FAIL idle_state got busy=%b done=%b ovf=%b hi=%0d lo=%0d want all 0",
               bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL idle_no_done got %0d done pulses want 0", done_seen);
    end
    hold(1'b0, 4);
  endtask

  task automatic test_basic();
    int n;
    bit got;
    int d0;
    pulse_start();
    exp_q.push_back('{hi: 8'd37, lo: 8'd53, ovf: 1'b0});
    d0 = done_seen;
    hold(1'b0, 20);
    hold(1'b1, 37);
    hold(1'b0, 53);
    bus.sig_in = 1'b1;
    wait_done(10, n, got);
    checks++;
    if (!got || n != 3) begin
      errors++;
      $display("FAIL basic_latency got done=%b after %0d cycles want 1 after 3", got, n);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got done=%b want 0", bus.done);
    end
    stop_cont();
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0 || done_seen != d0 + 1) begin
      errors++;
      $display("FAIL basic_single_done got busy=%b pulses=%0d want busy=0 pulses=1",
               bus.busy, done_seen - d0);
    end
  endtask

  task automatic test_armed_high();
    int n;
    bit got;
    pulse_start();
    exp_q.push_back('{hi: 8'd5, lo: 8'd7, ovf: 1'b0});
    hold(1'b1, 10);
    hold(1'b0, 6);
    hold(1'b1, 5);
    hold(1'b0, 7);
    bus.sig_in = 1'b1;
    wait_done(10, n, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL armed_high_done got no done within 10 cycles want done");
    end
    stop_cont();
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    hold(1'b0, 4);
    pulse_start();
    exp_q.push_back('{hi: 8'd5, lo: 8'd7, ovf: 1'b1});
    wait_done(400, n, got);
    checks++;
    if (!got || n != (1 << CW)) begin
      errors++;
      $display("FAIL timeout_cycles got done=%b after %0d cycles want 1 after %0d",
               got, n, 1 << CW);
    end
    repeat (3) tick();
    checks++;
    if (bus.ovf !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky got ovf=%b busy=%b want ovf=1 busy=0", bus.ovf, bus.busy);
    end
    pulse_start();
    checks++;
    if (bus.ovf !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears_ovf got ovf=%b busy=%b want ovf=0 busy=1",
               bus.ovf, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_seen;
    hold(1'b1, 8);
    hold(1'b0, 5);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got busy=%b want 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b ovf=%b hi=%0d lo=%0d want all 0",
               bus.busy, bus.done, bus.ovf, bus.high_cnt, bus.low_cnt);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    hold(1'b1, 10);
    hold(1'b0, 5);
    checks++;
    if (done_seen != d0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done got pulses=%0d busy=%b want 0 and 0",
               done_seen - d0, bus.busy);
    end
  endtask

  task automatic test_ena();
    int n;
    bit got;
    bit seen;
    pulse_start();
    exp_q.push_back('{hi: 8'd20, lo: 8'd9, ovf: 1'b0});
    hold(1'b0, 3);
    hold(1'b1, 8);
    bus.ena = 1'b0;
    repeat (10) tick();
    bus.ena = 1'b1;
    repeat (12) tick();
    hold(1'b0, 9);
    hold(1'b1, 2);
    bus.ena = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL ena_freeze_done got done=1 while ena=0 want 0");
    end
    bus.ena = 1'b1;
    wait_done(4, n, got);
    checks++;
    if (!got || n != 1) begin
      errors++;
      $display("FAIL ena_pending_done got done=%b after %0d cycles want 1 after 1", got, n);
    end
    stop_cont();
  endtask

`ifdef PULSE_CAPTURE_CONTINUOUS_EN
  task automatic test_continuous();
    int d0;
    hold(1'b0, 4);
    pulse_start();
    hold(1'b0, 5);
    done_cyc_q.delete();
    d0 = done_seen;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back('{hi: 8'd12, lo: 8'd20, ovf: 1'b0});
      hold(1'b1, 12);
      hold(1'b0, 20);
    end
    hold(1'b1, 5);
    checks++;
    if (done_seen != d0 + 4 || done_cyc_q.size() != 4) begin
      errors++;
      $display("FAIL cont_done_count got %0d want 4", done_seen - d0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (done_cyc_q[i+1] - done_cyc_q[i] != 32) begin
          errors++;
          $display("FAIL cont_spacing gap%0d got %0d want 32", i,
                   done_cyc_q[i+1] - done_cyc_q[i]);
        end
      end
    end
    pulse_start();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_abort got busy=%b want 0", bus.busy);
    end
    hold(1'b0, 20);
    hold(1'b1, 10);
    checks++;
    if (done_seen != d0 + 4) begin
      errors++;
      $display("FAIL cont_abort_no_done got %0d pulses want 4", done_seen - d0);
    end
  endtask
`else
  task automatic test_start_ignored();
    int n;
    bit got;
    hold(1'b0, 4);
    pulse_start();
    exp_q.push_back('{hi: 8'd12, lo: 8'd8, ovf: 1'b0});
    hold(1'b0, 4);
    hold(1'b1, 6);
    pulse_start();
    hold(1'b1, 5);
    hold(1'b0, 8);
    bus.sig_in = 1'b1;
    wait_done(10, n, got);
    checks++;
    if (!got || n != 3) begin
      errors++;
      $display("FAIL busy_start_ignored got done=%b after %0d cycles want 1 after 3", got, n);
    end
  endtask
`endif

  initial begin
    bus.ena    = 1'b1;
    bus.start  = 1'b0;
    bus.sig_in = 1'b0;
    test_reset();
    test_basic();
    test_armed_high();
    test_timeout();
    test_reset_mid();
    test_ena();
`ifdef PULSE_CAPTURE_CONTINUOUS_EN
    test_continuous();
`else
    test_start_ignored();
`endif
    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d results outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
